// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the parallel-to-serial bit source.
// Holds the two-state FSM encoding and the bit-counter sizing helper.
// No logic lives here; the top imports it.
package serial_bit_source_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that indexes the remaining bits of a w-bit word.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial converter: WIDTH-bit words in, one bit per clock out.
// Latency: first bit appears the cycle after the accepting edge; WIDTH cycles per word.
// Backpressure: data_ready only in IDLE or on a word's final bit, so back-to-back words stay gap-free.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last
);

  localparam int             CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             xfer;
  logic             head_nxt;

  // Ready depends only on registered state and count, never on data_valid.
  assign data_ready = (state == IDLE) || ((state == SHIFT) && (bit_cnt == '0));
  assign xfer       = data_valid && data_ready;
  assign head_nxt   = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];

  // Next-state logic: load, shift toward the head, reload seamlessly, or drop to idle.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_nxt = data_in;
          cnt_nxt   = CNT_MAX;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          cnt_nxt   = bit_cnt - CW'(1);
        end else if (xfer) begin
          shreg_nxt = data_in;
          cnt_nxt   = CNT_MAX;
        end else begin
          shreg_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, shift register and counter; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Output flops are loaded from next-state values so they line up with the word being shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      ser_out   <= (state_nxt == SHIFT) ? head_nxt : IDLE_BIT;
      ser_valid <= (state_nxt == SHIFT);
      last      <= (state_nxt == SHIFT) && (cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench for serial_bit_source: expected bits queued at issue, popped by monitors.
// Two instances: MSB-first (main) and LSB-first.
module tb_serial_bit_source;

  typedef struct packed {
    logic b;
    logic lst;
    logic cont;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in0 = '0, data_in1 = '0;
  logic       data_valid0 = 1'b0, data_valid1 = 1'b0;
  logic       data_ready0, data_ready1;
  logic       ser_out0, ser_out1, ser_valid0, ser_valid1, last0, last1;

  exp_t exp0[$];
  exp_t exp1[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;

  logic       det_en = 1'b0;
  logic [3:0] det_sh = '0;
  logic [7:0] det_hits = '0;
  int         det_pos = 0;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in0), .data_valid(data_valid0),
    .data_ready(data_ready0), .ser_out(ser_out0), .ser_valid(ser_valid0), .last(last0)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .data_valid(data_valid1),
    .data_ready(data_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1), .last(last1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the MSB-first instance, plus a downstream 1011 detector model.
  always @(negedge clk) begin
    exp_t e;
    if (ser_valid0) begin
      if (exp0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_bit0: got bit %0b expected none at %0t", ser_out0, $time);
      end else begin
        e = exp0.pop_front();
        chk("ser_out0", 32'(ser_out0), 32'(e.b));
        chk("last0", 32'(last0), 32'(e.lst));
        if (e.cont) chk("gapless0", 32'(prev_v0), 32'd1);
      end
    end else begin
      chk("idle_out0", 32'(ser_out0), 32'd0);
      chk("idle_last0", 32'(last0), 32'd0);
    end
    chk("ready0", 32'(data_ready0), 32'(!ser_valid0 || last0));
    prev_v0 = ser_valid0;
    if (!det_en) begin
      det_sh = '0;
      det_pos = 0;
      det_hits = '0;
    end else if (ser_valid0) begin
      det_sh = {det_sh[2:0], ser_out0};
      if (det_sh == 4'b1011 && det_pos < 8) det_hits[det_pos] = 1'b1;
      det_pos++;
    end
  end

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    exp_t e;
    if (ser_valid1) begin
      if (exp1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_bit1: got bit %0b expected none at %0t", ser_out1, $time);
      end else begin
        e = exp1.pop_front();
        chk("ser_out1", 32'(ser_out1), 32'(e.b));
        chk("last1", 32'(last1), 32'(e.lst));
        if (e.cont) chk("gapless1", 32'(prev_v1), 32'd1);
      end
    end else begin
      chk("idle_out1", 32'(ser_out1), 32'd0);
    end
    chk("ready1", 32'(data_ready1), 32'(!ser_valid1 || last1));
    prev_v1 = ser_valid1;
  end

  // Queue a word's expected MSB-first bits, offer it, and wait (bounded) for acceptance.
  task automatic send0(input logic [7:0] w, input logic contig);
    bit ok;
    ok = 1'b0;
    data_in0 = w;
    data_valid0 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (data_ready0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      exp_t e;
      e.b = w[i];
      e.lst = (i == 0);
      e.cont = (i == 7) ? contig : 1'b1;
      exp0.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("latency_valid0", 32'(ser_valid0), 32'd1);
    data_valid0 = 1'b0;
  endtask

  initial begin
    // Reset held: every output at its reset value.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser_out0", 32'(ser_out0), 32'd0);
    chk("rst_ser_valid0", 32'(ser_valid0), 32'd0);
    chk("rst_last0", 32'(last0), 32'd0);
    chk("rst_ready0", 32'(data_ready0), 32'd1);
    chk("rst_ready1", 32'(data_ready1), 32'd1);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Single word 1011_0110 with detector hits expected after bits 4 and 7.
    det_en = 1'b1;
    send0(8'b1011_0110, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("detector_hits", 32'(det_hits), 32'h48);
    det_en = 1'b0;

    // Back-to-back: second word follows the first with no idle bit.
    send0(8'hB1, 1'b0);
    send0(8'h0B, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    // Stall: a pulse during the third bit of 8'h00 must be ignored.
    send0(8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_ready_low", 32'(data_ready0), 32'd0);
    data_in0 = 8'hFF;
    data_valid0 = 1'b1;
    @(posedge clk);
    #1;
    data_valid0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_back_idle", 32'(ser_valid0), 32'd0);

    // LSB-first instance: 8'h0D shifts out 1,0,1,1,0,0,0,0.
    begin
      logic [7:0] seq;
      seq = 8'b1011_0000;
      for (int i = 7; i >= 0; i--) begin
        exp_t e;
        e.b = seq[i];
        e.lst = (i == 0);
        e.cont = (i != 7);
        exp1.push_back(e);
      end
    end
    data_in1 = 8'h0D;
    data_valid1 = 1'b1;
    @(posedge clk);
    #1;
    data_valid1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset mid-word during the 5th bit of 8'hAA.
    send0(8'hAA, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_word_valid", 32'(ser_valid0), 32'd1);
    #1;
    rst = 1'b1;
    exp0.delete();
    #1;
    chk("async_rst_out", 32'(ser_out0), 32'd0);
    chk("async_rst_valid", 32'(ser_valid0), 32'd0);
    chk("async_rst_ready", 32'(data_ready0), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send0(8'h55, 1'b0);
    repeat (12) @(posedge clk);
    #1;

    chk("queue0_drained", 32'(exp0.size()), 32'd0);
    chk("queue1_drained", 32'(exp1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
